// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: shared encodings for the multi-cycle shift unit.
//   mode_e  - shift mode as decoded by the ALU (SLL/SRL/SRA/ROL)
//   state_e - seq_shifter FSM states
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/result bundle between the ALU and seq_shifter.
//   start, mode, din, shamt - request, driven by the master (ALU)
//   busy, done, dout        - status/result, driven by the slave (shifter)
interface seq_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    import seq_shifter_pkg::*;

    logic               start;
    mode_e              mode;
    logic [WIDTH-1:0]   din;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   dout;

    modport master (
        output start, mode, din, shamt,
        input  busy, done, dout
    );

    modport slave (
        input  start, mode, din, shamt,
        output busy, done, dout
    );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// shift_step: combinational single-step shifter.
//   value - operand
//   k     - shift distance, 0..STEP
//   mode  - SLL/SRL/SRA/ROL
//   result- value shifted by k
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [K_W-1:0]   k,
    input  mode_e            mode,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] sra;

    // k never exceeds WIDTH, so the right-hand term covers k=0 (shift by
    // WIDTH yields 0) and k=WIDTH (left term is 0) without special cases.
    assign rol = (value << k) | (value >> (WIDTH - int'(k)));
    assign sra = WIDTH'($signed(value) >>> k);

    always_comb begin
        result = value;
        case (mode)
            MODE_SLL: result = value << k;
            MODE_SRL: result = value >> k;
            MODE_SRA: result = sra;
            MODE_ROL: result = rol;
            default:  result = value;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit, up to STEP bits per clock.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; aborts any operation in flight
//   bus   - seq_shifter_if slave: start/mode/din/shamt in,
//           busy/done/dout out (all outputs registered)
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input logic          clk,
    input logic          reset,
    seq_shifter_if.slave bus
);

    localparam int K_W = $clog2(STEP + 1);

    state_e             state_q, state_nxt;
    mode_e              mode_q, mode_nxt;
    logic [WIDTH-1:0]   dout_q, dout_nxt;
    logic [SHAMT_W-1:0] rem_q, rem_nxt;
    logic               busy_q, done_q;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   stepped;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .value  (dout_q),
        .k      (k),
        .mode   (mode_q),
        .result (stepped)
    );

    // k = min(STEP, remaining)
    always_comb begin
        if (32'(rem_q) >= STEP) k = K_W'(STEP);
        else                    k = K_W'(rem_q);
    end

    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        dout_nxt  = dout_q;
        rem_nxt   = rem_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    dout_nxt  = bus.din;
                    mode_nxt  = bus.mode;
                    rem_nxt   = bus.shamt;
                    state_nxt = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                dout_nxt = stepped;
                rem_nxt  = rem_q - SHAMT_W'(k);
                if (rem_nxt == '0) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SLL;
            dout_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            dout_q  <= dout_nxt;
            rem_q   <= rem_nxt;
            // Status flags registered from the next state so they line up
            // with state_q without decoding it on the output path.
            busy_q  <= (state_nxt == ST_SHIFT);
            done_q  <= (state_nxt == ST_DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed self-checking bench for seq_shifter.
//   u1 - STEP=1, SHAMT_W=5
//   u4 - STEP=4, SHAMT_W=6 (covers shifts >= WIDTH)
module tb_seq_shifter;
    import seq_shifter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) b1 ();
    seq_shifter_if #(.WIDTH(32), .SHAMT_W(6)) b4 ();

    seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    seq_shifter #(.WIDTH(32), .SHAMT_W(6), .STEP(4)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input mode_e m,
                         input logic [31:0] x, input logic [5:0] sh);
        if (d == 1) begin
            b1.start = s; b1.mode = m; b1.din = x; b1.shamt = sh[4:0];
        end else begin
            b4.start = s; b4.mode = m; b4.din = x; b4.shamt = sh;
        end
    endtask

    function automatic logic get_busy(input int d);
        return (d == 1) ? b1.busy : b4.busy;
    endfunction

    function automatic logic get_done(input int d);
        return (d == 1) ? b1.done : b4.done;
    endfunction

    function automatic logic [31:0] get_dout(input int d);
        return (d == 1) ? b1.dout : b4.dout;
    endfunction

    // Called at a negedge; start is taken at the next posedge. Returns at the
    // negedge of cycle 1.
    task automatic issue(input int d, input mode_e m, input logic [31:0] x, input logic [5:0] sh);
        drive(d, 1'b1, m, x, sh);
        @(posedge clk);
        @(negedge clk);
        drive(d, 1'b0, MODE_SLL, 32'h0, 6'd0);
    endtask

    // Walks negedges from cycle c0 until done is seen (lat=-1 on timeout).
    task automatic observe(input int d, input int c0, input int maxc,
                           output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int c = c0; c <= maxc; c++) begin
            check("busy_done_excl", 64'(get_busy(d) & get_done(d)), 64'd0);
            if (get_busy(d)) nbusy++;
            if (get_done(d)) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input int d, input mode_e m, input logic [31:0] x,
                       input logic [5:0] sh, input int exp_lat, input int exp_busy,
                       input logic [31:0] exp_dout);
        int lat, nb;
        issue(d, m, x, sh);
        observe(d, 1, exp_lat + 20, lat, nb);
        check({tag, "_lat"},  64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(nb),  64'(exp_busy));
        check({tag, "_dout"}, 64'(get_dout(d)), 64'(exp_dout));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(get_done(d)), 64'd0);
        @(negedge clk);
        check({tag, "_hold"}, 64'(get_dout(d)), 64'(exp_dout));
    endtask

    initial begin
        int lat, nb, ndone;
        reset = 1'b1;
        drive(1, 1'b0, MODE_SLL, 32'h0, 6'd0);
        drive(4, 1'b0, MODE_SLL, 32'h0, 6'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy1", 64'(b1.busy), 64'd0);
        check("rst_done1", 64'(b1.done), 64'd0);
        check("rst_dout1", 64'(b1.dout), 64'd0);
        check("rst_busy4", 64'(b4.busy), 64'd0);
        check("rst_dout4", 64'(b4.dout), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // STEP=1
        run("sll2",    1, MODE_SLL, 32'h0000_0001, 6'd2,  3,  2,  32'h0000_0004);
        run("sra31",   1, MODE_SRA, 32'h8000_0000, 6'd31, 32, 31, 32'hFFFF_FFFF);
        run("srl31",   1, MODE_SRL, 32'h8000_0000, 6'd31, 32, 31, 32'h0000_0001);
        run("zero1",   1, MODE_SRA, 32'hDEAD_BEEF, 6'd0,  1,  0,  32'hDEAD_BEEF);
        run("rol5",    1, MODE_ROL, 32'hF000_0001, 6'd5,  6,  5,  32'h0000_003E);

        // STEP=4, including shifts >= WIDTH
        run("srl6",    4, MODE_SRL, 32'h8000_0000, 6'd6,  3,  2,  32'h0200_0000);
        run("rol1",    4, MODE_ROL, 32'h8000_0001, 6'd1,  2,  1,  32'h0000_0003);
        run("zero4",   4, MODE_ROL, 32'hDEAD_BEEF, 6'd0,  1,  0,  32'hDEAD_BEEF);
        run("rol32",   4, MODE_ROL, 32'h1234_5678, 6'd32, 9,  8,  32'h1234_5678);
        run("rol35",   4, MODE_ROL, 32'h8000_0001, 6'd35, 10, 9,  32'h0000_000C);
        run("sll40",   4, MODE_SLL, 32'hFFFF_FFFF, 6'd40, 11, 10, 32'h0000_0000);
        run("srl33",   4, MODE_SRL, 32'hFFFF_FFFF, 6'd33, 10, 9,  32'h0000_0000);
        run("sra63",   4, MODE_SRA, 32'h8000_0000, 6'd63, 17, 16, 32'hFFFF_FFFF);
        run("sra40p",  4, MODE_SRA, 32'h7FFF_FFFF, 6'd40, 11, 10, 32'h0000_0000);

        // Back-to-back: start held during the DONE cycle
        issue(1, MODE_SLL, 32'h0000_0003, 6'd1);
        observe(1, 1, 20, lat, nb);
        check("b2b_a_lat",  64'(lat), 64'd2);
        check("b2b_a_dout", 64'(b1.dout), 64'h6);
        issue(1, MODE_SRL, 32'h0000_00F0, 6'd4);
        observe(1, 1, 20, lat, nb);
        check("b2b_b_lat",  64'(lat), 64'd5);
        check("b2b_b_busy", 64'(nb),  64'd4);
        check("b2b_b_dout", 64'(b1.dout), 64'h0F);
        repeat (2) @(negedge clk);

        // start while busy is ignored
        issue(1, MODE_SLL, 32'h0000_0001, 6'd8);
        @(negedge clk);
        drive(1, 1'b1, MODE_SRL, 32'h1234_5678, 6'd3);
        @(negedge clk);
        drive(1, 1'b0, MODE_SLL, 32'h0, 6'd0);
        observe(1, 3, 30, lat, nb);
        check("ign_lat",  64'(lat), 64'd9);
        check("ign_dout", 64'(b1.dout), 64'h100);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (b1.done) ndone++;
        end
        check("ign_extra_done", 64'(ndone), 64'd0);
        check("ign_hold", 64'(b1.dout), 64'h100);

        // reset mid-SHIFT
        issue(1, MODE_SRA, 32'h8000_0000, 6'd20);
        repeat (4) @(negedge clk);
        check("mid_busy_pre", 64'(b1.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy",  64'(b1.busy), 64'd0);
        check("mid_done",  64'(b1.done), 64'd0);
        check("mid_dout",  64'(b1.dout), 64'd0);
        check("mid_state", 64'(u1.state_q), 64'(ST_IDLE));
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (b1.done || b1.busy) ndone++;
        end
        check("mid_no_late", 64'(ndone), 64'd0);
        run("post_rst", 1, MODE_SLL, 32'h0000_0005, 6'd3, 4, 3, 32'h0000_0028);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
